// File: rtl/pack_pkg.sv
// pack_pkg: shared types and constants for the coeff_bit_packer slice.
//   state_t      packer FSM states (IDLE / RUN / FLUSH)
//   *_DEF        default geometry used by the top and its interface
//   IN_W         input word width for the default geometry
//   FILL_W       width of the fill counter for the default geometry
//   clamp_bits() maps an out-of-range kept-bits request onto the full lane
package pack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int LANE_W_DEF = 16;
    localparam int LANES_DEF  = 4;
    localparam int OUT_W_DEF  = 64;
    localparam int BUF_W_DEF  = 128;
    localparam int IN_W       = LANES_DEF * LANE_W_DEF;
    localparam int FILL_W     = $clog2(BUF_W_DEF + 1);

    // 0 or anything wider than a lane falls back to keeping the whole lane.
    function automatic int clamp_bits(input int bits, input int lane_w);
        return ((bits < 1) || (bits > lane_w)) ? lane_w : bits;
    endfunction

endpackage

// File: rtl/coeff_bit_packer_if.sv
// coeff_bit_packer_if: input beat stream and packed output stream.
//   in_data/in_valid/in_last/in_ready      upstream (serializer) side
//   out_data/out_valid/out_last/out_ready  downstream (DMA) side
// Handshake: a transfer happens in every cycle where valid && ready are
// both high at the rising clock edge; a source holds data/last stable
// while valid is high and ready is low.
// Modports: master = the agent driving beats and accepting words,
//           slave  = the packer.
interface coeff_bit_packer_if #(
    parameter int IN_W  = pack_pkg::IN_W,
    parameter int OUT_W = pack_pkg::OUT_W_DEF
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/lane_extract.sv
// lane_extract: combinational lane compactor.
//   in_data_i  LANES lanes of LANE_W bits, lane i at [i*LANE_W +: LANE_W]
//   bits_i     kept bits per lane, must already be in 1..LANE_W
//   field_o    {lane[LANES-1][b-1:0], ..., lane[0][b-1:0]} left-justified
//   p_o        packed width LANES*b
module lane_extract
    import pack_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int IW     = LANE_W * LANES,
    parameter int CB_W   = $clog2(LANE_W) + 1,
    parameter int PW     = FILL_W
) (
    input  logic [IW-1:0]   in_data_i,
    input  logic [CB_W-1:0] bits_i,
    output logic [IW-1:0]   field_o,
    output logic [PW-1:0]   p_o
);
    logic [IW-1:0] mask;
    logic [IW-1:0] acc;

    always_comb begin
        mask = (IW'(1) << bits_i) - IW'(1);
        acc  = '0;
        // Highest lane first, so it ends up in the most significant position.
        for (int i = LANES - 1; i >= 0; i--) begin
            acc = (acc << bits_i) | (IW'(in_data_i[i*LANE_W +: LANE_W]) & mask);
        end
        p_o     = PW'(LANES) * PW'(bits_i);
        field_o = acc << (PW'(IW) - p_o);
    end
endmodule

// File: rtl/coeff_bit_packer.sv
// coeff_bit_packer: packs the low b bits of each input lane into a gap-free
// MSB-first OUT_W-bit stream, with end-of-packet zero-padded flush.
//   clk, rstn    clock, asynchronous active-low reset
//   cfg_bits     kept bits per lane (0 or >LANE_W -> LANE_W, flags cfg_err)
//   cfg_bypass   pass input straight through (only when OUT_W == IN_W)
//   bus          coeff_bit_packer_if.slave: in_* beats, out_* words
//   busy         FSM not in IDLE
//   cfg_err      sticky: an illegal cfg_bits was latched
// Optional macro PACK_STATS_EN adds stat_in_beats, stat_out_words,
// stat_pad_bits (wrapping counters, cleared only by rstn).
module coeff_bit_packer
    import pack_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int BUF_W  = BUF_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [$clog2(LANE_W):0] cfg_bits,
    input  logic                    cfg_bypass,
    coeff_bit_packer_if.slave       bus,
    output logic                    busy,
    output logic                    cfg_err
`ifdef PACK_STATS_EN
    ,
    output logic [31:0]             stat_in_beats,
    output logic [31:0]             stat_out_words,
    output logic [15:0]             stat_pad_bits
`endif
);
    localparam int IW   = LANE_W * LANES;
    localparam int FW   = $clog2(BUF_W + 1);
    localparam int CB_W = $clog2(LANE_W) + 1;
    localparam logic [FW-1:0] OUT_W_F = FW'(OUT_W);
    localparam bit BYPASS_OK = (OUT_W == IW);

    state_t           state_q, state_d;
    logic [FW-1:0]    fill_q, fill_d, fill_pop, pop_amt, p;
    logic [BUF_W-1:0] buf_q, buf_d, wide_field;
    logic [IW-1:0]    field;
    logic [CB_W-1:0]  bits_q, cfg_clamped, b_eff;
    logic             bypass_q, cfg_err_q, out_valid_q, out_last_q;
    logic             out_valid_d, out_last_d;
    logic             cfg_illegal, idle, byp_eff, pk_in_ready;
    logic             accept, pk_push, pop;
    logic [FW:0]      room_sum;
    logic [OUT_W-1:0] byp_data;

    assign cfg_illegal = (cfg_bits == '0) || (int'(cfg_bits) > LANE_W);
    assign cfg_clamped = CB_W'(clamp_bits(int'(cfg_bits), LANE_W));

    // While IDLE the configuration that will be latched is already in force,
    // so the first beat is sized and routed with the live inputs.
    assign idle    = (state_q == IDLE);
    assign b_eff   = idle ? cfg_clamped : bits_q;
    assign byp_eff = idle ? (BYPASS_OK && cfg_bypass) : bypass_q;

    lane_extract #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .IW     (IW),
        .CB_W   (CB_W),
        .PW     (FW)
    ) u_lane_extract (
        .in_data_i (bus.in_data),
        .bits_i    (b_eff),
        .field_o   (field),
        .p_o       (p)
    );

    assign wide_field = {field, {(BUF_W - IW){1'b0}}};

    // Registered fill only: no combinational out_ready -> in_ready path.
    assign room_sum    = {1'b0, fill_q} + {1'b0, p};
    assign pk_in_ready = (state_q != FLUSH) && (room_sum <= (FW + 1)'(BUF_W));

    generate
        if (BYPASS_OK) begin : g_byp
            assign byp_data = bus.in_data;
        end else begin : g_no_byp
            assign byp_data = '0;
        end
    endgenerate

    assign bus.in_ready  = byp_eff ? bus.out_ready : pk_in_ready;
    assign bus.out_valid = byp_eff ? bus.in_valid  : out_valid_q;
    assign bus.out_last  = byp_eff ? bus.in_last   : out_last_q;
    // Bits below fill are always zero, so the top slice is already padded.
    assign bus.out_data  = byp_eff ? byp_data : buf_q[BUF_W-1 -: OUT_W];

    assign accept  = bus.in_valid && bus.in_ready;
    assign pk_push = accept && !byp_eff;
    assign pop     = out_valid_q && bus.out_ready && !byp_eff;

    always_comb begin
        pop_amt = '0;
        if (pop) begin
            pop_amt = (fill_q > OUT_W_F) ? OUT_W_F : fill_q;
        end
        // Pop first, then append the new beat directly below what remains.
        fill_pop = fill_q - pop_amt;
        buf_d    = buf_q << pop_amt;
        fill_d   = fill_pop;
        if (pk_push) begin
            buf_d  = buf_d | (wide_field >> fill_pop);
            fill_d = fill_pop + p;
        end

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (byp_eff) state_d = bus.in_last ? IDLE : RUN;
                    else         state_d = bus.in_last ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept && bus.in_last) state_d = bypass_q ? IDLE : FLUSH;
            end
            FLUSH: begin
                if (fill_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == FLUSH) ? (fill_d != '0)
                                         : ((state_d == RUN) && (fill_d >= OUT_W_F));
        out_last_d  = (state_d == FLUSH) && (fill_d != '0) && (fill_d <= OUT_W_F);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            buf_q       <= '0;
            bits_q      <= CB_W'(LANE_W);
            bypass_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (idle && accept) begin
                bits_q   <= cfg_clamped;
                bypass_q <= BYPASS_OK && cfg_bypass;
                if (cfg_illegal) cfg_err_q <= 1'b1;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign cfg_err = cfg_err_q;

`ifdef PACK_STATS_EN
    logic [31:0] in_beats_q, out_words_q;
    logic [15:0] pad_bits_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_beats_q  <= '0;
            out_words_q <= '0;
            pad_bits_q  <= '0;
        end else begin
            if (accept) in_beats_q <= in_beats_q + 32'd1;
            if (bus.out_valid && bus.out_ready) out_words_q <= out_words_q + 32'd1;
            // Pad is whatever the final word lacks of a full OUT_W.
            if (pop && out_last_q) pad_bits_q <= pad_bits_q + 16'(OUT_W_F - fill_q);
        end
    end

    assign stat_in_beats  = in_beats_q;
    assign stat_out_words = out_words_q;
    assign stat_pad_bits  = pad_bits_q;
`endif

endmodule

// File: tb/tb_coeff_bit_packer.sv
// tb_coeff_bit_packer: directed and randomized bench for coeff_bit_packer.
// The reference keeps the packed stream as a queue of bits in stream order.
module tb_coeff_bit_packer;

    logic       clk;
    logic       rstn;
    logic [4:0] cfg_bits;
    logic       cfg_bypass;
    logic       busy;
    logic       cfg_err;

    coeff_bit_packer_if #(.IN_W(64), .OUT_W(64)) bus ();

    coeff_bit_packer dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_bits   (cfg_bits),
        .cfg_bypass (cfg_bypass),
        .bus        (bus),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_pass;
    logic        exp_q[$];
    bit          m_in_pkt;
    bit          m_flush;
    bit          m_err;
    int          m_b;
    int          n_words;
    int          last_idx;
    logic [63:0] first_word;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int clampb(input int c);
        return (c < 1 || c > 16) ? 16 : c;
    endfunction

    function automatic logic [63:0] beat_data(input int dmode, input int k);
        case (dmode)
            1:       return 64'h7FFF_7FFF_7FFF_7FFF;
            2:       return {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
            3:       return 64'h0ABC_0DEF_0123_0456;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_flush  = 1'b0;
        m_err    = 1'b0;
        m_b      = 16;
    endtask

    // Called just after a falling edge with inputs set; returns on the next
    // falling edge. Checks outputs and advances the reference stream.
    task automatic cycle(output bit acc);
        logic        ir, ov, ol;
        logic [63:0] od, w, d;
        int          p, sz, n;
        #1;
        ir = bus.in_ready;
        ov = bus.out_valid;
        ol = bus.out_last;
        od = bus.out_data;
        d  = bus.in_data;
        sz = exp_q.size();
        p  = 4 * (m_in_pkt ? m_b : clampb(int'(cfg_bits)));
        chk1("in_ready", ir, !m_flush && (sz + p <= 128));
        chk1("out_valid", ov, m_flush ? (sz > 0) : (sz >= 64));
        chk1("out_last", ol, m_flush && sz > 0 && sz <= 64);
        chk1("busy", busy, m_in_pkt);
        chk1("cfg_err", cfg_err, m_err);
        acc = bus.in_valid && ir;
        if (ov && bus.out_ready) begin
            w = '0;
            for (int i = 0; i < 64; i++) if (i < sz) w[63-i] = exp_q[i];
            chk64("out_data", od, w);
            n_words++;
            if (n_words == 1) first_word = od;
            if (ol) last_idx = n_words;
            n = (sz < 64) ? sz : 64;
            repeat (n) void'(exp_q.pop_front());
            if (m_flush && exp_q.size() == 0) begin
                m_flush  = 1'b0;
                m_in_pkt = 1'b0;
            end
        end
        if (acc) begin
            if (!m_in_pkt) begin
                m_b      = clampb(int'(cfg_bits));
                m_in_pkt = 1'b1;
                if (cfg_bits == 0 || cfg_bits > 16) m_err = 1'b1;
            end
            for (int i = 3; i >= 0; i--)
                for (int j = m_b - 1; j >= 0; j--) exp_q.push_back(d[i*16+j]);
            if (bus.in_last) m_flush = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // rmode: 0 out_ready=1, 1 random valid/ready, 2 out_ready held low first.
    task automatic send_pkt(input int cfg, input int nbeats, input int dmode,
                            input int rmode, input int cfg_mid);
        int          k, cyc;
        bit          acc;
        logic [63:0] cur;
        k = 0; cyc = 0; n_words = 0; last_idx = 0;
        cur = beat_data(dmode, 0);
        while ((k < nbeats || m_in_pkt) && cyc < 3000) begin
            bus.in_valid = (k < nbeats) && (rmode != 1 || $urandom_range(0, 3) != 0);
            bus.in_data  = cur;
            bus.in_last  = (k == nbeats - 1);
            cfg_bits     = (k > 0 && cfg_mid >= 0) ? 5'(cfg_mid) : 5'(cfg);
            case (rmode)
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                2:       bus.out_ready = (cyc >= 12);
                default: bus.out_ready = 1'b1;
            endcase
            cycle(acc);
            if (acc) begin
                k++;
                cur = beat_data(dmode, k);
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk32("beats_sent", k, nbeats);
        chk1("drain_busy", busy, 1'b0);
    endtask

    initial begin
        logic [63:0] d1, d2;
        bit          acc;
        n_chk = 0; n_pass = 0;
        model_reset();
        rstn = 1'b0; cfg_bits = 5'd16; cfg_bypass = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_out_last", bus.out_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_cfg_err", cfg_err, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // b=15 all-ones: 960 bits -> 15 words, last flagged on word 15.
        send_pkt(15, 16, 1, 0, -1);
        chk32("t1_words", n_words, (16 * 4 * 15 + 63) / 64);
        chk32("t1_last_idx", last_idx, 15);

        // b=16: output equals input words.
        send_pkt(16, 3, 2, 0, -1);
        chk64("t2_first", first_word, 64'h0004_0003_0002_0001);
        chk32("t2_last_idx", last_idx, 3);

        // b=12 single beat, zero padded.
        send_pkt(12, 1, 3, 0, -1);
        chk64("t3_word", first_word, 64'hABCD_EF12_3456_0000);
        chk32("t3_last_idx", last_idx, 1);

        // Backpressure until the buffer is full.
        send_pkt(16, 6, 0, 2, -1);

        // Illegal cfg_bits, then mid-packet change.
        send_pkt(0, 5, 0, 0, 5);
        chk1("t5_cfg_err", cfg_err, 1'b1);

        // Randomized packets.
        for (int r = 0; r < 10; r++)
            send_pkt($urandom_range(1, 18), $urandom_range(1, 12), 0, 1, -1);

        // Reset while flushing with 40 bits buffered.
        cfg_bits = 5'd10; bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_data = beat_data(0, 0);
        cycle(acc);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        cycle(acc);
        rstn = 1'b0;
        #1;
        chk1("t6_out_valid", bus.out_valid, 1'b0);
        chk1("t6_out_last", bus.out_last, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        send_pkt(7, 4, 0, 1, -1);

        // Bypass: combinational pass-through, config held for the packet.
        d1 = beat_data(0, 0); d2 = beat_data(0, 0);
        cfg_bits = 5'd16; cfg_bypass = 1'b1; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.in_data = d1;
        #1;
        chk64("byp_data", bus.out_data, d1);
        chk1("byp_valid", bus.out_valid, 1'b1);
        chk1("byp_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk1("byp_busy", busy, 1'b1);
        cfg_bypass = 1'b0; bus.in_last = 1'b1; bus.in_data = d2; bus.out_ready = 1'b0;
        #1;
        chk1("byp_ready_bp", bus.in_ready, 1'b0);
        chk64("byp_data2", bus.out_data, d2);
        chk1("byp_last", bus.out_last, 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk1("byp_ready2", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        #1;
        chk1("byp_idle", busy, 1'b0);
        chk1("byp_out_valid", bus.out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
